myproject_mul_share_arb: RTL and testbench
==========================================

Name: myproject_mul_share_arb

Overview:
- Time-multiplexes one signed DIN_WIDTH x DIN_WIDTH pipelined multiplier among NUM_REQ requesters.
- Arbitration is round-robin. Each result returns to its originator, identified by a tagged one-hot response.
- Sits between parallel dense/attention compute lanes and the single shared DSP product unit. It lets the HLS-generated kernels trade DSP count for throughput.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIN_WIDTH, 16, signed operand width.
- DOUT_WIDTH, 26, product width delivered (low bits of the full product).
- NUM_STAGE, 2, multiplier pipeline depth in cycles (>=1).

Ports:
- ap_clk  in  1  clock; all logic is rising-edge.
- ap_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*DIN_WIDTH  operand A; requester i occupies slice [i*DIN_WIDTH +: DIN_WIDTH].
- req_b  in  NUM_REQ*DIN_WIDTH  operand B, same packing.
- rsp_valid  out  NUM_REQ  one-hot result valid, addressed to the originating requester.
- rsp_data  out  DOUT_WIDTH  signed product, shared bus.
- rsp_ready  in  1  consumer accept; when low, stalls the whole pipeline.

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr=0; all pipeline valid bits=0.
  - rsp_valid=0, rsp_data=0, req_ready=0.
- Stall: stall = rsp_valid_any & ~rsp_ready.
  - While stalled, every pipeline stage holds and req_ready=0.
- Arbitration (combinational, same cycle):
  - If not stalled, grant the first requester with req_valid=1, searching upward from rr_ptr and wrapping modulo NUM_REQ.
  - req_ready = grant one-hot. A transfer occurs on req_valid[i] & req_ready[i].
  - req_ready never asserts without the matching req_valid.
  - On a transfer, rr_ptr <= (granted index + 1) mod NUM_REQ.
  - With no transfer, rr_ptr is held.
- Pipeline:
  - Stage 0 registers a, b and a one-hot tag.
  - The product is computed as a full signed 2*DIN_WIDTH product. Its low DOUT_WIDTH bits are carried through NUM_STAGE registers total.
  - rsp_valid/rsp_data/rsp_id appear exactly NUM_STAGE cycles after the transfer, given no stall.
  - Each stall cycle adds one cycle of latency.
- Throughput: one issue per cycle when rsp_ready=1; back-to-back issues from different requesters need no bubbles.
- Output hold: rsp_valid and rsp_data hold stable while rsp_ready=0, and drop the cycle after acceptance unless the next stage is valid.
- Simultaneous events:
  - Stall and a new request in the same cycle: no grant is issued, and rr_ptr does not move.
  - An output accepted in the same cycle as a new issue: both proceed, with no bubble.
- Single requester: repeated grants to the same index are legal (the pointer skips the idle ones).
- Reset mid-operation: in-flight products are discarded with no response emitted, and the pointer returns to 0.
- Ordering: results emerge in issue order. rsp_valid is never multi-hot.

Optional Feature:
- Macro: MYPROJECT_MUL_ARB_STATS_EN.
- Defined:
  - Adds output port stat_issue_cnt (32 bits), a wrapping count of accepted transfers.
  - Adds output port stat_stall_cnt (32 bits), a wrapping count of stall cycles.
  - Both counters reset to 0 on ap_rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single transfer: reset, then req_valid=0001, a=3, b=-5 -> req_ready=0001 the same cycle; rsp_valid=0001 and rsp_data=-15 (26-bit two's complement) 2 cycles later.
- Round-robin fairness: all four requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1 with one grant per cycle; rsp_valid sequence matches, delayed by 2 cycles.
- Extremes: a=-32768, b=-32768 -> full product 2^30, rsp_data = low 26 bits = 0. Also a=32767, b=-1 -> rsp_data=-32767.
- Backpressure: hold rsp_ready=0 for 3 cycles while results are in flight -> req_ready=0, rsp_data stable, rr_ptr unchanged; on release the results drain in order with none lost or duplicated.
- Reset mid-flight: assert ap_rst asynchronously with 2 ops in the pipe -> outputs go to 0 immediately; no stale rsp_valid after release; first grant goes to the lowest valid index.
- With MYPROJECT_MUL_ARB_STATS_EN defined: 10 transfers plus 3 stall cycles -> stat_issue_cnt=10, stat_stall_cnt=3.

Source files
------------

// File: rtl/myproject_mul_share_arb.sv
// Shares one pipelined signed multiplier among NUM_REQ requesters with round-robin arbitration.
// Define MYPROJECT_MUL_ARB_STATS_EN to add the stat_issue_cnt / stat_stall_cnt counters.
module myproject_mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 26,
  parameter int NUM_STAGE  = 2
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic signed [DOUT_WIDTH-1:0]  rsp_data,
  input  logic                          rsp_ready
`ifdef MYPROJECT_MUL_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_issue_cnt,
  output logic [31:0]                   stat_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]             rr_ptr;
  logic [PTR_W-1:0]             ptr_nxt;
  logic [NUM_REQ-1:0]           grant;
  logic                         stall;
  logic                         advance;
  logic signed [DIN_WIDTH-1:0]  sel_a;
  logic signed [DIN_WIDTH-1:0]  sel_b;
  logic signed [DIN_WIDTH-1:0]  a_q;
  logic signed [DIN_WIDTH-1:0]  b_q;
  logic signed [DOUT_WIDTH-1:0] prod;
  logic [NUM_REQ-1:0]           tag_q [NUM_STAGE];

  function automatic int wrap_add(input int base, input int off);
    return (base + off) % NUM_REQ;
  endfunction

  assign stall   = (|rsp_valid) & ~rsp_ready;
  assign advance = ~stall;

  // Scan offsets from the far end down so the nearest valid requester above rr_ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    grant = '0;
    if (advance && !ap_rst) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[PTR_W'(wrap_add(int'(rr_ptr), k))]) begin
          grant = '0;
          grant[PTR_W'(wrap_add(int'(rr_ptr), k))] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    ptr_nxt = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[i*DIN_WIDTH +: DIN_WIDTH];
        sel_b   = req_b[i*DIN_WIDTH +: DIN_WIDTH];
        ptr_nxt = PTR_W'(wrap_add(i, 1));
      end
    end
  end

  assign req_ready = grant;

  // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
  // NOTE: datapath registers are reset as well, so rsp_data reads 0 straight out of reset.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      if (|grant) rr_ptr <= ptr_nxt;
      if (advance) begin
        a_q <= sel_a;
        b_q <= sel_b;
      end
    end
  end

  // A zero tag marks an empty stage; the tag doubles as the valid bit.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int s = 0; s < NUM_STAGE; s++) tag_q[s] <= '0;
    end else if (advance) begin
      tag_q[0] <= grant;
      for (int s = 1; s < NUM_STAGE; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Low DOUT_WIDTH bits of the sign-extended product equal those of the full 2*DIN_WIDTH product.
  assign prod = DOUT_WIDTH'(a_q) * DOUT_WIDTH'(b_q);

  if (NUM_STAGE == 1) begin : g_one_stage
    assign rsp_data = prod;
  end else begin : g_multi_stage
    logic signed [DOUT_WIDTH-1:0] prod_q [1:NUM_STAGE-1];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        for (int s = 1; s < NUM_STAGE; s++) prod_q[s] <= '0;
      end else if (advance) begin
        prod_q[1] <= prod;
        for (int s = 2; s < NUM_STAGE; s++) prod_q[s] <= prod_q[s-1];
      end
    end

    assign rsp_data = prod_q[NUM_STAGE-1];
  end

  assign rsp_valid = tag_q[NUM_STAGE-1];

`ifdef MYPROJECT_MUL_ARB_STATS_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (|grant) stat_issue_cnt <= stat_issue_cnt + 32'd1;
      if (stall)  stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Self-checking bench for myproject_mul_share_arb: directed cases plus random traffic against
// a transaction-level model (in-flight queue with per-op countdown).
module tb_myproject_mul_share_arb;

  localparam int NUM_REQ    = 4;
  localparam int DIN_WIDTH  = 16;
  localparam int DOUT_WIDTH = 26;
  localparam int NUM_STAGE  = 2;

  logic                         ap_clk = 1'b0;
  logic                         ap_rst;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DIN_WIDTH-1:0] req_a;
  logic [NUM_REQ*DIN_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DOUT_WIDTH-1:0]        rsp_data;
  logic                         rsp_ready;
`ifdef MYPROJECT_MUL_ARB_STATS_EN
  logic [31:0]                  stat_issue_cnt;
  logic [31:0]                  stat_stall_cnt;
`endif

  myproject_mul_share_arb #(
    .NUM_REQ(NUM_REQ), .DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH), .NUM_STAGE(NUM_STAGE)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_ready(rsp_ready)
`ifdef MYPROJECT_MUL_ARB_STATS_EN
    ,
    .stat_issue_cnt(stat_issue_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int                    id;
    logic [DOUT_WIDTH-1:0] prod;
    int                    cnt;   // edges left before the result is visible
  } op_t;

  op_t inflight[$];
  int  m_ptr;
  int  m_issue;
  int  m_stall;
  int  n_tests;
  int  n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DOUT_WIDTH-1:0] trunc(input longint v);
    return v[DOUT_WIDTH-1:0];
  endfunction

  function automatic logic [DOUT_WIDTH-1:0] model_prod(input int i);
    logic signed [DIN_WIDTH-1:0] a;
    logic signed [DIN_WIDTH-1:0] b;
    a = req_a[i*DIN_WIDTH +: DIN_WIDTH];
    b = req_b[i*DIN_WIDTH +: DIN_WIDTH];
    return trunc(longint'(a) * longint'(b));
  endfunction

  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input logic stall);
    int pick;
    pick = -1;
    if (!stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (pick < 0 && v[(m_ptr + k) % NUM_REQ]) pick = (m_ptr + k) % NUM_REQ;
      end
    end
    return pick;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*DIN_WIDTH +: DIN_WIDTH] = DIN_WIDTH'(a);
    req_b[i*DIN_WIDTH +: DIN_WIDTH] = DIN_WIDTH'(b);
  endtask

  task automatic model_clear();
    inflight.delete();
    m_ptr   = 0;
    m_issue = 0;
    m_stall = 0;
  endtask

  // Called at a falling edge with inputs already set; checks, then advances one clock.
  task automatic cycle(input string tag);
    logic               vis;
    logic               stall;
    logic [NUM_REQ-1:0] exp_rv;
    logic [NUM_REQ-1:0] exp_rdy;
    int                 pick;
    logic [DOUT_WIDTH-1:0] p;
    #1;
    vis    = (inflight.size() > 0) && (inflight[0].cnt == 0);
    stall  = vis && !rsp_ready;
    exp_rv = '0;
    if (vis) exp_rv[inflight[0].id] = 1'b1;
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(exp_rv));
    if (vis) check({tag, ".rsp_data"}, 64'(rsp_data), 64'(inflight[0].prod));
    pick    = model_pick(req_valid, stall);
    exp_rdy = '0;
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    check({tag, ".req_ready"}, 64'(req_ready), 64'(exp_rdy));
    p = (pick >= 0) ? model_prod(pick) : '0;
    @(posedge ap_clk);
    if (stall) begin
      m_stall++;
    end else begin
      if (vis) void'(inflight.pop_front());
      foreach (inflight[i]) if (inflight[i].cnt > 0) inflight[i].cnt--;
      if (pick >= 0) begin
        inflight.push_back('{id: pick, prod: p, cnt: NUM_STAGE - 1});
        m_ptr = (pick + 1) % NUM_REQ;
        m_issue++;
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic sync_reset();
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int order [6] = '{0, 1, 2, 3, 0, 1};
    n_tests   = 0;
    n_fail    = 0;
    model_clear();
    ap_rst    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state
    #1;
    check("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst.rsp_data",  64'(rsp_data),  64'(0));
    check("rst.req_ready", 64'(req_ready), 64'(0));
    req_valid = 4'b1111;
    #1;
    check("rst.req_ready_held", 64'(req_ready), 64'(0));
    req_valid = '0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    model_clear();

    // Single transfer: 3 * -5 on requester 0
    set_op(0, 3, -5);
    req_valid = 4'b0001;
    #1;
    check("single.req_ready_same_cycle", 64'(req_ready), 64'(4'b0001));
    cycle("single.issue");
    req_valid = '0;
    cycle("single.wait");
    #1;
    check("single.rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    check("single.rsp_data",  64'(rsp_data),  64'(trunc(-15)));
    cycle("single.out");
    cycle("single.drop");

    // Round-robin fairness with all requesters valid
    sync_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, i + 1, 10 * (i + 1));
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr.order%0d", i), 64'(req_ready), 64'(1) << order[i]);
      cycle($sformatf("rr.c%0d", i));
    end
    req_valid = '0;
    repeat (3) cycle("rr.drain");

    // Extremes
    set_op(2, -32768, -32768);
    req_valid = 4'b0100;
    cycle("ext.issue0");
    set_op(3, 32767, -1);
    req_valid = 4'b1000;
    cycle("ext.issue1");
    req_valid = '0;
    #1;
    check("ext.min_min", 64'(rsp_data), 64'(trunc(0)));
    cycle("ext.out0");
    #1;
    check("ext.max_neg1", 64'(rsp_data), 64'(trunc(-32767)));
    cycle("ext.out1");
    cycle("ext.drop");

    // Backpressure: hold rsp_ready low for 3 cycles with results in flight
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 100 + i, -7 - i);
    req_valid = 4'b1111;
    cycle("bp.issue0");
    cycle("bp.issue1");
    rsp_ready = 1'b0;
    repeat (3) cycle("bp.stall");
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (5) cycle("bp.drain");

    // Asynchronous reset with two operations in the pipe
    req_valid = 4'b0011;
    cycle("rstmid.issue0");
    cycle("rstmid.issue1");
    #2;
    ap_rst = 1'b1;
    #1;
    check("rstmid.rsp_valid", 64'(rsp_valid), 64'(0));
    check("rstmid.rsp_data",  64'(rsp_data),  64'(0));
    check("rstmid.req_ready", 64'(req_ready), 64'(0));
    model_clear();
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    req_valid = 4'b0110;
    #1;
    check("rstmid.first_grant", 64'(req_ready), 64'(4'b0010));
    cycle("rstmid.post0");
    req_valid = '0;
    repeat (4) cycle("rstmid.post");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req_valid = NUM_REQ'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (NUM_STAGE + 4) cycle("rand.drain");
    check("end.inflight_empty", 64'(inflight.size()), 64'(0));

`ifdef MYPROJECT_MUL_ARB_STATS_EN
    check("stats.issue", 64'(stat_issue_cnt), 64'(m_issue));
    check("stats.stall", 64'(stat_stall_cnt), 64'(m_stall));
    sync_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, i, i);
    req_valid = 4'b1111;
    repeat (9) cycle("stats10.issue");
    req_valid = 4'b0001;
    cycle("stats10.issue_last");
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (3) cycle("stats10.stall");
    rsp_ready = 1'b1;
    repeat (4) cycle("stats10.drain");
    #1;
    check("stats10.issue", 64'(stat_issue_cnt), 64'(10));
    check("stats10.stall", 64'(stat_stall_cnt), 64'(3));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
